// File: rtl/sumsq_seq.sv
// sumsq_seq: sequential sum of squares of up to four 3-bit operands, one square per cycle
module sumsq_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  len,
   input  logic [11:0] data,
   output logic        busy,
   output logic        done,
   output logic [7:0]  sum
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  len_q, len_d, idx_q, idx_d;
   logic [11:0] data_q, data_d;
   logic [7:0]  acc_q, acc_d, sum_q, sum_d;
   logic [2:0]  elem;
   logic [5:0]  sq;
   // operand select feeding the single shared squarer
   always_comb begin
      elem = idx_q == 2'd0 ? data_q[2:0] : idx_q == 2'd1 ? data_q[5:3] :
             idx_q == 2'd2 ? data_q[8:6] : data_q[11:9];
      sq   = {3'b000, elem} * {3'b000, elem};
   end
   // next-state logic: latch on start, accumulate in RUN, publish total on entry to DONE
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      data_d  = data_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            len_d   = len;
            data_d  = data;
            idx_d   = 2'd0;
            acc_d   = 8'd0;
         end
         RUN: begin
            acc_d = acc_q + {2'b00, sq};
            if (idx_q == len_q) begin
               sum_d   = acc_d;
               state_d = DONE;
            end else idx_d = idx_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= 2'd0;
         data_q  <= 12'd0;
         idx_q   <= 2'd0;
         acc_q   <= 8'd0;
         sum_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
      end
   end
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
   assign sum  = sum_q;
endmodule

// File: tb/tb_sumsq_seq.sv
// tb_sumsq_seq: table-driven, corner-case and randomized checks of sumsq_seq
module tb_sumsq_seq;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  len;
   logic [11:0] data;
   logic        busy, done;
   logic [7:0]  sum;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  len;
      logic [11:0] data;
      int          exp;
   } vec_t;
   vec_t vecs[6];

   sumsq_seq dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .data(data),
      .busy(busy), .done(done), .sum(sum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int model(input logic [1:0] l, input logic [11:0] d);
      int s = 0;
      for (int i = 0; i <= int'(l); i++) begin
         int e = int'((d >> (3 * i)) & 12'd7);
         s += e * e;
      end
      return s;
   endfunction

   task automatic run_op(input logic [1:0] l, input logic [11:0] d, input int exp,
                         input bit noisy, input string nm);
      int c, bc, n;
      logic [7:0] s;
      n = int'(l) + 1;
      @(negedge clk);
      start = 1'b1; len = l; data = d;
      @(negedge clk);
      start = 1'b0; c = 0; bc = 0;
      while (!done && c <= 8) begin
         bc += int'(busy);
         if (noisy) begin
            start = 1'($urandom);
            len   = 2'($urandom);
            data  = 12'($urandom);
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      chk({nm, " latency"}, c, n);
      chk({nm, " busy cycles"}, bc, n);
      chk({nm, " busy in done"}, int'(busy), 0);
      chk({nm, " sum"}, int'(sum), exp);
      s = sum;
      @(negedge clk);
      chk({nm, " done width"}, int'(done), 0);
      chk({nm, " idle busy"}, int'(busy), 0);
      @(negedge clk);
      chk({nm, " sum hold"}, int'(sum), int'(s));
   endtask

   initial begin
      int pulses, last, dcnt;
      logic [1:0]  rl;
      logic [11:0] rd;
      vecs[0] = '{2'd3, 12'h3EB, 84};
      vecs[1] = '{2'd0, 12'h007, 49};
      vecs[2] = '{2'd3, 12'hFFF, 196};
      vecs[3] = '{2'd1, 12'h01A, 13};
      vecs[4] = '{2'd1, 12'hE09, 2};
      vecs[5] = '{2'd2, 12'h0B4, 56};
      rst = 1'b1; start = 1'b1; len = 2'd3; data = 12'hFFF;
      repeat (2) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset sum", int'(sum), 0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("idle after reset", int'(busy), 0);

      for (int i = 0; i < 6; i++) run_op(vecs[i].len, vecs[i].data, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
      run_op(2'd3, 12'h3EB, 84, 1'b1, "ignored restart");

      @(negedge clk);
      start = 1'b1; len = 2'd3; data = 12'h3EB;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort sum", int'(sum), 0);
      dcnt = 0;
      repeat (6) begin
         @(negedge clk);
         dcnt += int'(done);
      end
      chk("abort no done", dcnt, 0);
      run_op(2'd2, 12'h0B4, 56, 1'b0, "after abort");

      @(negedge clk);
      start = 1'b1; len = 2'd1; data = 12'h01A;
      pulses = 0; last = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 15) start = 1'b0;
         if (done) begin
            pulses++;
            chk("b2b sum", int'(sum), 13);
            if (last >= 0) chk("b2b period", c - last, 4);
            else chk("b2b first", c, 2);
            last = c;
         end
      end
      chk("b2b pulses", pulses, 4);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         rl = 2'($urandom);
         rd = 12'($urandom);
         run_op(rl, rd, model(rl, rd), 1'($urandom), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
